ysyx_25020047_ifu: RTL and testbench

- Instruction fetch stage sitting directly upstream of the decode stage.
- Accepts a fetch PC from the PC logic and issues a single-outstanding request to instruction memory over a valid/ready bus.
- Captures the returned 32-bit instruction and holds it under a valid/ready handshake until decode consumes it.
- Handles misaligned PCs, bus errors, response timeout and flush.

---
 rtl/ysyx_25020047_ifu.sv | 127 ++++++++++++
 tb/tb_ysyx_25020047_ifu.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: one outstanding imem request, result held for decode under valid/ready.
// Covers misaligned PCs, bus errors, response timeout, flush, and draining late responses.
module ysyx_25020047_ifu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              imem_rsp_err,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [1:0]        inst_err,
    output logic              inst_valid,
    input  logic              inst_ready
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e            state_q;
    logic              pending_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        err_q;
    logic              inst_valid_q;
    logic              req_valid_q;
    logic              req_hs;

    assign req_hs         = (state_q == S_REQ) && req_valid_q && imem_req_ready;
    assign pc_ready       = (state_q == S_IDLE) && !pending_q && !flush;
    assign imem_req_valid = req_valid_q;
    assign imem_addr      = addr_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_err       = err_q;
    assign inst_valid     = inst_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            addr_q       <= '0;
            err_q        <= 2'b00;
            inst_valid_q <= 1'b0;
            req_valid_q  <= 1'b0;
        end else begin
            // A handshake completes even under flush; any response retires the outstanding request.
            if (req_hs)
                pending_q <= 1'b1;
            else if (imem_rsp_valid)
                pending_q <= 1'b0;

            if (req_hs)
                cnt_q <= '0;
            else if (state_q == S_WAIT && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CNT_W'(1);

            if (flush) begin
                state_q      <= S_IDLE;
                inst_valid_q <= 1'b0;
                req_valid_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (pc_valid && pc_ready) begin
                            addr_q    <= pc_in;
                            inst_pc_q <= pc_in;
                            if (pc_in[1:0] != 2'b00) begin
                                inst_q       <= '0;
                                err_q        <= 2'b01;
                                inst_valid_q <= 1'b1;
                                state_q      <= S_OUT;
                            end else begin
                                req_valid_q <= 1'b1;
                                state_q     <= S_REQ;
                            end
                        end
                    end
                    S_REQ: begin
                        if (imem_req_ready) begin
                            req_valid_q <= 1'b0;
                            state_q     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rsp_valid) begin
                            inst_q       <= imem_rsp_data;
                            err_q        <= imem_rsp_err ? 2'b10 : 2'b00;
                            inst_valid_q <= 1'b1;
                            state_q      <= S_OUT;
                        end else if (cnt_q == CNT_LAST) begin
                            inst_q       <= '0;
                            err_q        <= 2'b11;
                            inst_valid_q <= 1'b1;
                            state_q      <= S_OUT;
                        end
                    end
                    S_OUT: begin
                        if (inst_ready) begin
                            inst_valid_q <= 1'b0;
                            state_q      <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Bench for ysyx_25020047_ifu: behavioural imem with programmable latency plus an expected-result queue.
module tb_ysyx_25020047_ifu;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_err;
    logic        inst_valid;
    logic        inst_ready = 1'b0;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;

    // memory model knobs: latency 0 = never respond, k = response valid k-1 edges after handshake
    int          mem_lat = 1;
    logic [31:0] mem_data = '0;
    logic        mem_err = 1'b0;
    int          cd;
    int          hs_cnt;
    logic [31:0] pend_data;
    logic        pend_err;

    always #5 clk = ~clk;

    ysyx_25020047_ifu #(.ADDR_W(32), .TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready), .flush(flush),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready)
    );

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cd             <= 0;
            hs_cnt         <= 0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
            imem_rsp_err   <= 1'b0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                hs_cnt <= hs_cnt + 1;
                if (mem_lat == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_data;
                    imem_rsp_err   <= mem_err;
                end else if (mem_lat > 1) begin
                    cd        <= mem_lat - 1;
                    pend_data <= mem_data;
                    pend_err  <= mem_err;
                end
            end else if (cd == 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= pend_data;
                imem_rsp_err   <= pend_err;
                cd             <= 0;
            end else if (cd > 1) begin
                cd <= cd - 1;
            end
        end
    end

    task automatic send_pc(input logic [31:0] a);
        int n = 0;
        while (!pc_ready && n < 50) begin @(negedge clk); n++; end
        total++;
        if (pc_ready !== 1'b1) begin bad++; $display("FAIL send_pc_ready got=%b exp=1", pc_ready); end
        pc_in = a; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({inst_valid, imem_req_valid, pc_ready} !== 3'b001) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=001", {inst_valid, imem_req_valid, pc_ready});
        end
        total++;
        if ({inst, inst_pc, inst_err, imem_addr} !== '0) begin
            bad++; $display("FAIL reset_data inst=%h pc=%h err=%b addr=%h exp all zero", inst, inst_pc, inst_err, imem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int n = 0;
        mem_lat = 1; mem_data = 32'h00100093; mem_err = 1'b0; imem_req_ready = 1'b1;
        sb.push_back('{inst: 32'h00100093, pc: 32'h80000000, err: 2'b00});
        send_pc(32'h80000000);
        while (!inst_valid && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n != 2) begin bad++; $display("FAIL basic_latency got=%0d exp=2 (edges after accept edge)", n); end
        e = sb.pop_front();
        total++;
        if ({inst, inst_pc, inst_err} !== {e.inst, e.pc, e.err}) begin
            bad++; $display("FAIL basic_out got=%h/%h/%b exp=%h/%h/%b", inst, inst_pc, inst_err, e.inst, e.pc, e.err);
        end
        inst_ready = 1'b1; @(negedge clk); inst_ready = 1'b0;
        total++;
        if ({inst_valid, pc_ready} !== 2'b01) begin bad++; $display("FAIL basic_ret got=%b exp=01", {inst_valid, pc_ready}); end
    endtask

    task automatic test_stream;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            logic [31:0] d;
            logic [31:0] a;
            d = $urandom; a = 32'h80000100 + 32'(i * 4);
            mem_lat = i + 1; mem_data = d; mem_err = (i % 2 == 1);
            sb.push_back('{inst: d, pc: a, err: (i % 2 == 1) ? 2'b10 : 2'b00});
            send_pc(a);
            while (!inst_valid && n < 50) begin @(negedge clk); n++; end
            total++;
            if (n != i + 2) begin bad++; $display("FAIL stream_latency[%0d] got=%0d exp=%0d", i, n, i + 2); end
            e = sb.pop_front();
            total++;
            if ({inst, inst_pc, inst_err} !== {e.inst, e.pc, e.err}) begin
                bad++; $display("FAIL stream_out[%0d] got=%h/%h/%b exp=%h/%h/%b", i, inst, inst_pc, inst_err, e.inst, e.pc, e.err);
            end
            inst_ready = 1'b1; @(negedge clk); inst_ready = 1'b0;
        end
        mem_err = 1'b0;
    endtask

    task automatic test_backpressure;
        int n = 0;
        int h0;
        h0 = hs_cnt;
        imem_req_ready = 1'b0; mem_lat = 1; mem_data = 32'hCAFE0013;
        sb.push_back('{inst: 32'hCAFE0013, pc: 32'h80000004, err: 2'b00});
        send_pc(32'h80000004);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({imem_req_valid, imem_addr} !== {1'b1, 32'h80000004}) begin
                bad++; $display("FAIL bp_req_hold[%0d] got=%b/%h exp=1/80000004", i, imem_req_valid, imem_addr);
            end
            @(negedge clk);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        total++;
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_drop got=%b exp=0", imem_req_valid); end
        while (!inst_valid && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n != 1) begin bad++; $display("FAIL bp_latency got=%0d exp=1", n); end
        e = sb[0];
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({inst_valid, inst, inst_pc, inst_err} !== {1'b1, e.inst, e.pc, e.err}) begin
                bad++; $display("FAIL bp_out_hold[%0d] got=%b/%h/%h/%b exp=1/%h/%h/%b", i, inst_valid, inst, inst_pc, inst_err, e.inst, e.pc, e.err);
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        inst_ready = 1'b1; @(negedge clk); inst_ready = 1'b0;
        total++;
        if (hs_cnt - h0 != 1) begin bad++; $display("FAIL bp_handshakes got=%0d exp=1", hs_cnt - h0); end
    endtask

    task automatic test_misaligned;
        int h0;
        h0 = hs_cnt;
        sb.push_back('{inst: 32'h0, pc: 32'h80000002, err: 2'b01});
        send_pc(32'h80000002);
        total++;
        if ({inst_valid, imem_req_valid} !== 2'b10) begin
            bad++; $display("FAIL mis_ctrl got=%b exp=10", {inst_valid, imem_req_valid});
        end
        e = sb.pop_front();
        total++;
        if ({inst, inst_pc, inst_err} !== {e.inst, e.pc, e.err}) begin
            bad++; $display("FAIL mis_out got=%h/%h/%b exp=%h/%h/%b", inst, inst_pc, inst_err, e.inst, e.pc, e.err);
        end
        inst_ready = 1'b1; @(negedge clk); inst_ready = 1'b0;
        total++;
        if (hs_cnt != h0) begin bad++; $display("FAIL mis_no_req got=%0d exp=%0d", hs_cnt, h0); end
    endtask

    task automatic test_timeout;
        int n = 0;
        int m = 0;
        mem_lat = 12; mem_data = 32'h11111111; imem_req_ready = 1'b1;
        sb.push_back('{inst: 32'h0, pc: 32'h80000020, err: 2'b11});
        send_pc(32'h80000020);
        while (!inst_valid && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n != 9) begin bad++; $display("FAIL to_latency got=%0d exp=9", n); end
        e = sb.pop_front();
        total++;
        if ({inst, inst_pc, inst_err} !== {e.inst, e.pc, e.err}) begin
            bad++; $display("FAIL to_out got=%h/%h/%b exp=%h/%h/%b", inst, inst_pc, inst_err, e.inst, e.pc, e.err);
        end
        inst_ready = 1'b1; @(negedge clk); inst_ready = 1'b0;
        while (!pc_ready && m < 50) begin @(negedge clk); m++; end
        total++;
        if (m != 3) begin bad++; $display("FAIL to_drain_pc_ready got=%0d exp=3", m); end
        @(negedge clk);
        total++;
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL to_late_discard got=%b exp=0", inst_valid); end
    endtask

    task automatic test_flush;
        int n = 0;
        mem_lat = 4; mem_data = 32'hDEADBEEF; imem_req_ready = 1'b1;
        send_pc(32'h80000008);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        total++;
        if (pc_ready !== 1'b0) begin bad++; $display("FAIL fl_pc_ready got=%b exp=0", pc_ready); end
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (inst_valid !== 1'b0) begin bad++; $display("FAIL fl_no_valid[%0d] got=%b exp=0", i, inst_valid); end
            @(negedge clk);
        end
        total++;
        if (pc_ready !== 1'b1) begin bad++; $display("FAIL fl_drained got=%b exp=1", pc_ready); end
        mem_lat = 1; mem_data = 32'h00A00513;
        sb.push_back('{inst: 32'h00A00513, pc: 32'h80000010, err: 2'b00});
        send_pc(32'h80000010);
        while (!inst_valid && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n != 2) begin bad++; $display("FAIL fl_next_latency got=%0d exp=2", n); end
        e = sb.pop_front();
        total++;
        if ({inst, inst_pc, inst_err} !== {e.inst, e.pc, e.err}) begin
            bad++; $display("FAIL fl_next_out got=%h/%h/%b exp=%h/%h/%b", inst, inst_pc, inst_err, e.inst, e.pc, e.err);
        end
        inst_ready = 1'b1; @(negedge clk); inst_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        int n = 0;
        // mid-REQ: request must vanish without waiting for a clock edge
        imem_req_ready = 1'b0;
        send_pc(32'h80000040);
        total++;
        if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL ar_req_pre got=%b exp=1", imem_req_valid); end
        #2 rst = 1'b0;
        #1;
        total++;
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL ar_req_drop got=%b exp=0", imem_req_valid); end
        @(negedge clk); rst = 1'b1;
        // mid-OUT: held instruction must vanish immediately
        imem_req_ready = 1'b1; mem_lat = 1; mem_data = 32'h0badf00d;
        send_pc(32'h80000044);
        while (!inst_valid && n < 50) begin @(negedge clk); n++; end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({inst_valid, inst_err, inst} !== {1'b0, 2'b00, 32'h0}) begin
            bad++; $display("FAIL ar_out_drop got=%b/%b/%h exp=0/00/0", inst_valid, inst_err, inst);
        end
        @(negedge clk); rst = 1'b1;
        // mid-WAIT with a request outstanding: pending must clear
        mem_lat = 0;
        send_pc(32'h80000048);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({pc_ready, imem_req_valid, inst_valid} !== 3'b100) begin
            bad++; $display("FAIL ar_wait got=%b exp=100", {pc_ready, imem_req_valid, inst_valid});
        end
        @(negedge clk); rst = 1'b1;
        n = 0;
        mem_lat = 1; mem_data = 32'h00000013;
        sb.push_back('{inst: 32'h00000013, pc: 32'h8000004C, err: 2'b00});
        send_pc(32'h8000004C);
        while (!inst_valid && n < 50) begin @(negedge clk); n++; end
        e = sb.pop_front();
        total++;
        if ({inst_valid, inst, inst_pc, inst_err} !== {1'b1, e.inst, e.pc, e.err}) begin
            bad++; $display("FAIL ar_after got=%b/%h/%h/%b exp=1/%h/%h/%b", inst_valid, inst, inst_pc, inst_err, e.inst, e.pc, e.err);
        end
        inst_ready = 1'b1; @(negedge clk); inst_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_backpressure();
        test_misaligned();
        test_timeout();
        test_flush();
        test_async_reset();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
